// File: rtl/latency_mem.sv
// resp_fifo: small generic FIFO holding responses in arrival order.
// Latency: a push is visible at the head one cycle later; pop and push may coincide at any occupancy.
// Backpressure: none internally; the caller must never push into a full FIFO.
module resp_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic         head_vld,
    output logic [W-1:0] head_dat
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     store [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop   = pop_rdy & (count != '0);
    assign head_vld = (count != '0);
    assign head_dat = store[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) store[i] <= '0;
        end else begin
            if (push_vld) begin
                store[wr_ptr] <= push_dat;
                wr_ptr        <= next_ptr(wr_ptr);
            end
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            case ({push_vld, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// latency_mem: behavioural line-organised backing memory with programmable read latency.
// Latency: response visible LATENCY cycles after the fire edge's cycle (same cycle as pipeline exit into an empty queue).
// Backpressure: cpu_req_ready drops while RESP_QUEUE_DEPTH responses are outstanding; cpu_resp_ready pops the queue head.
module latency_mem #(
    parameter int CPU_WIDTH        = 32,
    parameter int MEM_DATA_BITS    = 128,
    parameter int DEPTH            = 1024,
    parameter int WORD_ADDR_BITS   = 30,
    parameter int LATENCY          = 1,
    parameter int RESP_QUEUE_DEPTH = 4,
    parameter int WRITE_ACK        = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cpu_req_valid,
    output logic                      cpu_req_ready,
    input  logic [WORD_ADDR_BITS-1:0] cpu_req_addr,
    input  logic [CPU_WIDTH-1:0]      cpu_req_data,
    input  logic [CPU_WIDTH/8-1:0]    cpu_req_write,
    output logic                      cpu_resp_valid,
    input  logic                      cpu_resp_ready,
    output logic [CPU_WIDTH-1:0]      cpu_resp_data
);
    localparam int WORDS  = MEM_DATA_BITS / CPU_WIDTH;
    localparam int OFF_W  = $clog2(WORDS);
    localparam int LINE_W = $clog2(DEPTH);
    localparam int NBYTES = CPU_WIDTH / 8;
    localparam int CNT_W  = $clog2(RESP_QUEUE_DEPTH + 1);

    logic [MEM_DATA_BITS-1:0] mem [DEPTH];
    logic [OFF_W-1:0]         word_sel;
    logic [LINE_W-1:0]        line_sel;
    logic [MEM_DATA_BITS-1:0] rd_line, wr_line;
    logic [CPU_WIDTH-1:0]     rd_word;
    int                       woff;
    logic                     unused_addr;

    logic                 req_fire, is_wr, resp_fire, resp_pop;
    logic [CNT_W-1:0]     out_cnt;
    logic [LATENCY-1:0]   pipe_vld;
    logic [CPU_WIDTH-1:0] pipe_dat [LATENCY];
    logic                 exit_vld;
    logic [CPU_WIDTH-1:0] exit_dat;
    logic                 fifo_push, fifo_pop, fifo_nonempty;
    logic [CPU_WIDTH-1:0] fifo_head;

    // Bits above the line index are ignored, so addresses alias modulo DEPTH lines.
    assign word_sel    = cpu_req_addr[OFF_W-1:0];
    assign line_sel    = cpu_req_addr[OFF_W +: LINE_W];
    assign unused_addr = ^cpu_req_addr;

    always_comb begin
        woff    = int'(word_sel) * CPU_WIDTH;
        rd_line = mem[line_sel];
        rd_word = rd_line[woff +: CPU_WIDTH];
        wr_line = rd_line;
        for (int b = 0; b < NBYTES; b++) begin
            if (cpu_req_write[b]) wr_line[woff + 8*b +: 8] = cpu_req_data[8*b +: 8];
        end
    end

    // reset_n gates the fire so a request held during reset never commits a write.
    assign cpu_req_ready = (out_cnt < CNT_W'(RESP_QUEUE_DEPTH));
    assign req_fire      = cpu_req_valid & cpu_req_ready & reset_n;
    assign is_wr         = |cpu_req_write;
    assign resp_fire     = req_fire & (~is_wr | (WRITE_ACK != 0));

    always_ff @(posedge clk) begin
        if (req_fire && is_wr) mem[line_sel] <= wr_line;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < LATENCY; i++) pipe_dat[i] <= '0;
        end else begin
            pipe_vld[0] <= resp_fire;
            pipe_dat[0] <= is_wr ? '0 : rd_word;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    assign exit_vld = pipe_vld[LATENCY-1];
    assign exit_dat = pipe_dat[LATENCY-1];

    // An exit into an empty queue bypasses storage; it is stored only if not consumed at once.
    assign fifo_pop       = fifo_nonempty & cpu_resp_ready;
    assign fifo_push      = exit_vld & ~(~fifo_nonempty & cpu_resp_ready);
    assign cpu_resp_valid = fifo_nonempty | exit_vld;
    assign cpu_resp_data  = fifo_nonempty ? fifo_head : exit_dat;
    assign resp_pop       = cpu_resp_valid & cpu_resp_ready;

    resp_fifo #(
        .W     (CPU_WIDTH),
        .DEPTH (RESP_QUEUE_DEPTH)
    ) u_resp_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_vld (fifo_push),
        .push_dat (exit_dat),
        .pop_rdy  (fifo_pop),
        .head_vld (fifo_nonempty),
        .head_dat (fifo_head)
    );

    // Counts pipeline plus queue entries, which bounds the FIFO occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_cnt <= '0;
        end else begin
            case ({resp_fire, resp_pop})
                2'b10:   out_cnt <= out_cnt + CNT_W'(1);
                2'b01:   out_cnt <= out_cnt - CNT_W'(1);
                default: out_cnt <= out_cnt;
            endcase
        end
    end
endmodule

// File: doc/latency_mem.md
# latency_mem

Parametrised behavioural backing memory for CPU-side simulation and integration. It is the successor to the fixed one-cycle, always-ready memory model. It adds configurable word, line and depth sizes, a programmable read latency, a bounded response queue with `cpu_resp_ready` backpressure, and an optional write acknowledge. It sits where the cache or core would otherwise talk to main memory, so that stalls and long-latency paths can be exercised.

## Interface
- `CPU_WIDTH`, 32: word width in bits; a multiple of 8.
- `MEM_DATA_BITS`, 128: storage line width; a power-of-two multiple of `CPU_WIDTH`.
- `DEPTH`, 1024: number of lines; a power of two.
- `WORD_ADDR_BITS`, 30: width of the word address.
- `LATENCY`, 1: cycles from request accept to response-queue entry; must be ≥1.
- `RESP_QUEUE_DEPTH`, 4: maximum outstanding responses; must be ≥1.
- `WRITE_ACK`, 0: 1 means writes also return a response, with data 0.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `cpu_req_valid`  in  1  request valid.
- `cpu_req_ready`  out  1  request may be accepted.
- `cpu_req_addr`  in  `WORD_ADDR_BITS`  word address.
- `cpu_req_data`  in  `CPU_WIDTH`  write data.
- `cpu_req_write`  in  `CPU_WIDTH/8`  byte write strobes; all zero means read.
- `cpu_resp_valid`  out  1  response at queue head.
- `cpu_resp_ready`  in  1  consumer accepts the response.
- `cpu_resp_data`  out  `CPU_WIDTH`  response data.

## Operation
- **Request fire:** `req_fire = cpu_req_valid & cpu_req_ready`. At most one request per cycle.
- **Address split:**
  - Low `log2(MEM_DATA_BITS/CPU_WIDTH)` bits select the word within a line.
  - The next `log2(DEPTH)` bits select the line.
  - Higher bits are ignored, so addresses alias modulo `DEPTH`.
- **Read:** the selected word is captured at fire from the current array contents. Any write that fired in an earlier cycle is visible.
- **Write:**
  - Read-modify-write of the line.
  - Byte `i` of the word is replaced where `cpu_req_write[i]` is set.
  - All other bytes of the line are unchanged.
  - Committed at the fire edge.
- **Response-producing request:** any read, or a write when `WRITE_ACK=1`.
  - Enters a `LATENCY`-stage valid/data pipeline.
  - On leaving the pipeline it is pushed into a FIFO of `RESP_QUEUE_DEPTH` entries.
  - Responses are returned strictly in request order.
- **Writes with `WRITE_ACK=0`:** produce nothing and do not touch the queue or the counters.
- **Outstanding counter `out_cnt`:**
  - Range 0..`RESP_QUEUE_DEPTH`.
  - +1 on a response-producing fire; −1 on `cpu_resp_valid & cpu_resp_ready`.
  - Both in the same cycle leaves it unchanged.
- **Ready rule:** `cpu_req_ready = (out_cnt < RESP_QUEUE_DEPTH)`, decoded from registered state only. There is no combinational path from `cpu_resp_ready` or `cpu_req_valid`.
  - When `out_cnt == RESP_QUEUE_DEPTH`, writes with `WRITE_ACK=0` are also stalled. This keeps a single simple ready rule.
- **No overflow by construction:** pipeline entries plus queue entries never exceed `RESP_QUEUE_DEPTH`, so the FIFO never overflows.
- **Response outputs:** `cpu_resp_valid` = FIFO non-empty; `cpu_resp_data` = FIFO head.
  - Head data is held stable while valid and not ready.
- **Array:** contents are not initialised by reset; the bench preloads by hierarchical access.

## Timing
- **Reset (asynchronous, `reset_n` low):**
  - `cpu_resp_valid=0`, `cpu_resp_data=0`, `out_cnt=0`, all pipeline valids 0, FIFO empty, `cpu_req_ready=1`.
- **Reset mid-operation:**
  - All in-flight and queued responses are discarded.
  - Array writes already committed persist.
  - A request presented during reset is not accepted.
- **Read latency:** fire at edge t → `cpu_resp_valid` high in cycle t+`LATENCY`, if the queue ahead is empty.
- **Throughput:** one request per cycle is sustained with `cpu_resp_ready=1` only if `RESP_QUEUE_DEPTH ≥ LATENCY+1`. Otherwise `cpu_req_ready` bubbles.
- **Pop timing:** a pop at edge t frees a slot, and `cpu_req_ready` rises in the cycle after edge t.
- **Pipeline exit into empty FIFO:** visible on `cpu_resp_valid` in the same cycle as the exit, with no extra bubble.
- **Simultaneous FIFO push and pop:** legal at any occupancy, including full.
- **FIFO pointers:** wrap modulo `RESP_QUEUE_DEPTH`. Non-power-of-two depths must wrap explicitly.

## Test plan
- **Reset state, write, read-back:**
  - Stimulus: reset, then write 0xDEADBEEF to addr 5 with strobe 0xF, then read addr 5. `LATENCY=3`, `cpu_resp_ready=1`.
  - Required: `cpu_resp_valid` and `cpu_resp_data` are 0 during reset. Exactly one response, 0xDEADBEEF, 3 cycles after the read fires.
- **Byte mask:**
  - Stimulus: write 0x11223344 to addr 0, then 0xAABBCCDD with strobe 0b0101, then read addr 0; also read addrs 1–3 of the same line.
  - Required: data 0x11BB33DD, and the neighbouring words in the line are unchanged.
- **Backpressure:**
  - Stimulus: `RESP_QUEUE_DEPTH=2`, `cpu_resp_ready=0`, issue 4 reads to distinct words.
  - Required: `cpu_req_ready` drops after 2 fires. Data stays stable while held. After raising `cpu_resp_ready`, all 4 responses return in order.
- **Full throughput:**
  - Stimulus: `LATENCY=1`, `RESP_QUEUE_DEPTH=2`, `cpu_resp_ready=1`, 16 back-to-back reads.
  - Required: 16 fires in 16 consecutive cycles; responses in order.
- **Write acknowledge:**
  - Stimulus: `WRITE_ACK=1`, interleave write/read/write.
  - Required: 3 responses with data 0, read-data, 0.
  - Stimulus: `WRITE_ACK=0`, same sequence.
  - Required: 1 response.
- **Reset mid-flight and aliasing:**
  - Stimulus: with 2 responses queued, pulse `reset_n` low for a partial cycle.
  - Required: `cpu_resp_valid` drops immediately and stays 0 after release, and written data survives. An address equal to `DEPTH*WORDS + 5` reads the same word as addr 5.
